// File: rtl/loader_pkg.sv
// loader_pkg -- shared definitions for the program_loader block.
//   START_BYTE     : frame start marker (0xA5)
//   LEN_W          : width of the little-endian length field (16 bits)
//   loader_state_t : loader FSM states
//   length_ok()    : frame length acceptance rule (non-zero and fits in memory)
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN adds the CHECK state.
package loader_pkg;

  localparam logic [7:0] START_BYTE = 8'hA5;
  localparam int         LEN_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    CLEAR,
    DATA,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERROR
  } loader_state_t;

  function automatic logic length_ok(input logic [LEN_W-1:0] len, input int unsigned limit);
    return (len != '0) && (32'(len) <= limit);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// loader_timeout -- inter-byte gap watchdog.
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous active-high reset
//   enable  : count idle cycles only while high; counter is cleared when low
//   kick    : a byte arrived this cycle, restart the gap count
//   expired : high in the cycle that is the TIMEOUT_CYCLES-th consecutive
//             enabled cycle without a kick
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int GAP_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  // gap_reg holds the number of idle cycles already seen before this one,
  // so the current idle cycle is the last allowed one when it equals GAP_LAST.
  logic [GAP_W-1:0] gap_reg;

  assign expired = enable && !kick && (gap_reg == GAP_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_reg <= '0;
    end else if (!enable || kick || expired) begin
      gap_reg <= '0;
    end else begin
      gap_reg <= gap_reg + GAP_W'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// program_loader -- receives a framed program image over a byte stream and
// writes it into program memory while holding the CPU in reset.
// Frame: 0xA5, LEN_LO, LEN_HI, LEN payload bytes [, checksum byte].
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN -- a modulo-256 sum of the
// payload follows the payload and is verified before load_done.
// Ports:
//   clk           : clock, rising edge
//   reset         : asynchronous active-high reset
//   rx_valid      : one-cycle strobe, rx_data holds a received byte
//   rx_data       : received byte
//   write_enable  : program-memory byte write strobe (registered)
//   write_data    : byte to write
//   write_address : byte address of the write (upper 16 bits always 0)
//   clear_mem     : one-cycle program-memory clear pulse
//   cpu_hold      : holds the core in reset while a load is in progress
//   load_done     : one-cycle pulse on successful load
//   load_error    : sticky error flag, cleared by the next start byte
module program_loader
  import loader_pkg::*;
#(
  parameter int MEM_BYTES      = 1024,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        write_enable,
  output logic [7:0]  write_data,
  output logic [31:0] write_address,
  output logic        clear_mem,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam int unsigned MEM_LIMIT = MEM_BYTES;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam loader_state_t PAYLOAD_END = CHECK;
`else
  localparam loader_state_t PAYLOAD_END = DONE;
`endif

  loader_state_t    state_reg, state_next;
  logic [7:0]       len_lo_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] count_reg;
  // The write stage below doubles as the one-entry holding register: a byte
  // that arrives during CLEAR is captured here and presented to memory in
  // the first DATA cycle, after the clear pulse has been issued.
  logic             we_reg;
  logic [7:0]       wdata_reg;
  logic [LEN_W-1:0] waddr_reg;
  logic             error_reg;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]       sum_reg;
`endif

  logic accept;
  logic start_seen;
  logic payload_last;
  logic timer_en;
  logic timer_expired;

  assign start_seen   = rx_valid && (rx_data == START_BYTE);
  assign payload_last = (count_reg + LEN_W'(1)) == len_reg;
  assign timer_en     = !(state_reg inside {IDLE, DONE, ERROR});

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .enable  (timer_en),
    .kick    (rx_valid),
    .expired (timer_expired)
  );

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE, ERROR: begin
        if (start_seen) state_next = LEN_LO;
      end
      LEN_LO: begin
        if (rx_valid) state_next = LEN_HI;
      end
      LEN_HI: begin
        if (rx_valid) begin
          state_next = length_ok({rx_data, len_lo_reg}, MEM_LIMIT) ? CLEAR : ERROR;
        end
      end
      CLEAR: begin
        accept     = rx_valid;
        state_next = DATA;
      end
      DATA: begin
        if (count_reg == len_reg) begin
          // Whole payload already taken (single byte captured during CLEAR).
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          if (rx_valid) state_next = (rx_data == sum_reg) ? DONE : ERROR;
          else          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end else if (rx_valid) begin
          accept = 1'b1;
          if (payload_last) state_next = PAYLOAD_END;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (rx_valid) state_next = (rx_data == sum_reg) ? DONE : ERROR;
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (timer_expired) state_next = ERROR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      len_lo_reg <= '0;
      len_reg    <= '0;
      count_reg  <= '0;
      we_reg     <= 1'b0;
      wdata_reg  <= '0;
      waddr_reg  <= '0;
      error_reg  <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_reg    <= '0;
`endif
    end else begin
      state_reg <= state_next;
      we_reg    <= accept;

      if (state_reg == LEN_LO && rx_valid) len_lo_reg <= rx_data;

      if (state_reg == LEN_HI) begin
        count_reg <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_reg   <= '0;
`endif
        if (rx_valid) len_reg <= {rx_data, len_lo_reg};
      end

      if (accept) begin
        wdata_reg <= rx_data;
        waddr_reg <= count_reg;
        count_reg <= count_reg + LEN_W'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_reg   <= sum_reg + rx_data;
`endif
      end

      if (state_next == ERROR && state_reg != ERROR) begin
        error_reg <= 1'b1;
      end else if (start_seen && (state_reg == IDLE || state_reg == ERROR)) begin
        error_reg <= 1'b0;
      end
    end
  end

  assign write_enable  = we_reg;
  assign write_data    = wdata_reg;
  assign write_address = {{(32-LEN_W){1'b0}}, waddr_reg};
  assign clear_mem     = (state_reg == CLEAR);
  assign cpu_hold      = !(state_reg inside {IDLE, ERROR});
  assign load_done     = (state_reg == DONE);
  assign load_error    = error_reg;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader -- randomized frames checked cycle by cycle against a
// frame-level reference model, plus directed literal checks.
// Honours PROGRAM_LOADER_CHECKSUM_EN (appends a checksum byte to frames).
module tb_program_loader;

  localparam int MEM_BYTES = 1024;
  localparam int TIMEOUT   = 16;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        write_enable;
  logic [7:0]  write_data;
  logic [31:0] write_address;
  logic        clear_mem, cpu_hold, load_done, load_error;

  int checks = 0;
  int errors = 0;

  program_loader #(
    .MEM_BYTES(MEM_BYTES),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .write_enable(write_enable), .write_data(write_data), .write_address(write_address),
    .clear_mem(clear_mem), .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  // Tracks position in the frame, payload length, running sum and the idle gap;
  // produces the outputs expected during the next cycle.
  bit          m_active, m_complete, m_err;
  int          m_pos, m_n, m_gap, m_cyc, m_clear_cyc, m_done_cyc;
  logic [7:0]  m_lo, m_sum;
  bit          e_we, e_clr, e_done;
  logic [7:0]  e_wd = 8'h00;
  logic [31:0] e_wa = 32'h0;

  initial forever begin : model
    bit ended;
    int p;
    @(posedge clk or posedge reset);
    if (reset) begin
      m_active = 0; m_complete = 0; m_err = 0; m_pos = 0; m_n = 0; m_gap = 0;
      m_cyc = 0; m_clear_cyc = -10; m_done_cyc = -10; m_sum = 0; m_lo = 0;
      e_we = 0; e_clr = 0; e_done = 0;
    end else begin
      ended = 0;
      e_we = 0; e_clr = 0;
      if (m_active && m_complete && m_cyc == m_done_cyc) begin
        m_active = 0; m_complete = 0; ended = 1;
      end
      if (!m_active) begin
        if (!ended && rx_valid && rx_data == 8'hA5) begin
          m_active = 1; m_err = 0; m_pos = 0; m_gap = 0; m_sum = 0; m_clear_cyc = -10;
        end
      end else if (!m_complete) begin
        if (rx_valid) begin
          m_gap = 0;
          p = m_pos - 2;
          if (m_pos == 0) begin
            m_lo = rx_data;
          end else if (m_pos == 1) begin
            m_n = int'({rx_data, m_lo});
            if (m_n == 0 || m_n > MEM_BYTES) begin
              m_active = 0; m_err = 1;
            end else begin
              e_clr = 1; m_clear_cyc = m_cyc + 1;
            end
          end else if (p < m_n) begin
            e_we = 1; e_wd = rx_data; e_wa = 32'(p); m_sum = m_sum + rx_data;
            if (p == m_n - 1 && !CHK) begin
              // DONE can come no earlier than two cycles after CLEAR.
              m_complete = 1;
              m_done_cyc = (m_cyc + 1 > m_clear_cyc + 2) ? m_cyc + 1 : m_clear_cyc + 2;
            end
          end else begin
            if (rx_data == m_sum) begin
              m_complete = 1; m_done_cyc = m_cyc + 1;
            end else begin
              m_active = 0; m_err = 1;
            end
          end
          m_pos++;
        end else begin
          m_gap++;
          if (m_gap == TIMEOUT) begin
            m_active = 0; m_err = 1;
          end
        end
      end
      e_done = m_active && m_complete && (m_done_cyc == m_cyc + 1);
      m_cyc++;
    end
  end

  // ---------------- compare + observation counters ----------------
  int wr_count = 0, clr_count = 0, done_count = 0, clear_then_write = 0;
  bit prev_clear = 0;
  logic [23:0] wq[$];

  initial forever begin : compare
    @(negedge clk);
    if (reset) begin
      check("we_in_reset", write_enable, 0);
      check("clr_in_reset", clear_mem, 0);
      check("hold_in_reset", cpu_hold, 0);
      check("done_in_reset", load_done, 0);
      check("err_in_reset", load_error, 0);
      check("data_in_reset", write_data, 0);
      check("addr_in_reset", write_address, 0);
      prev_clear = 0;
    end else begin
      check("write_enable", write_enable, e_we);
      check("clear_mem", clear_mem, e_clr);
      check("cpu_hold", cpu_hold, m_active);
      check("load_done", load_done, e_done);
      check("load_error", load_error, m_err);
      if (e_we) begin
        check("write_data", write_data, e_wd);
        check("write_address", write_address, e_wa);
      end
      if (write_enable) begin
        wr_count++;
        wq.push_back({write_address[15:0], write_data});
        if (prev_clear && write_address == 0) clear_then_write++;
      end
      if (clear_mem) clr_count++;
      if (load_done) done_count++;
      prev_clear = clear_mem;
    end
  end

  // ---------------- stimulus helpers ----------------
  // All helpers start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [15:0] len, input bq_t payload, input int maxgap,
                            input int stop_after, input int chk_adj);
    bq_t s;
    logic [7:0] sum;
    int lim;
    sum = 8'h00;
    s.push_back(8'hA5); s.push_back(len[7:0]); s.push_back(len[15:8]);
    foreach (payload[i]) begin
      s.push_back(payload[i]);
      sum = sum + payload[i];
    end
    if (CHK && payload.size() != 0) s.push_back(sum + 8'(chk_adj));
    lim = (stop_after < s.size()) ? stop_after : s.size();
    for (int i = 0; i < lim; i++) begin
      send_byte(s[i]);
      if (i + 1 < lim) idle($urandom_range(maxgap, 0));
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end, checks=%0d", checks);
    $fatal(1);
  end

  initial begin : stim
    bq_t pl;
    int w0, c0, d0, q0, ct0, n, kind, gap;
    logic [7:0] exp_d [4];
    logic [7:0] g;
    logic [15:0] bl;

    // Reset state before any clock edge.
    #2;
    check("rst_we", write_enable, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_clr", clear_mem, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    // Basic frame A5 04 00 13 00 00 00, bytes back-to-back (byte 0 lands in CLEAR).
    w0 = wr_count; c0 = clr_count; d0 = done_count; q0 = wq.size(); ct0 = clear_then_write;
    pl = '{8'h13, 8'h00, 8'h00, 8'h00};
    send_frame(16'd4, pl, 0, 1000, 0);
    idle(4);
    $display("frame basic len=4");
    check("basic_writes", wr_count - w0, 4);
    check("basic_clears", clr_count - c0, 1);
    check("basic_done", done_count - d0, 1);
    check("basic_err", load_error, 0);
    check("clear_then_byte0", clear_then_write - ct0, 1);
    exp_d = '{8'h13, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      if (q0 + i < wq.size()) check("basic_wentry", 32'(wq[q0 + i]), {8'h0, 16'(i), exp_d[i]});
      else check("basic_wentry_missing", 0, 1);
    end

    // Oversize length 0x0401.
    w0 = wr_count; c0 = clr_count;
    pl.delete();
    send_frame(16'h0401, pl, 1, 3, 0);
    idle(4);
    $display("frame oversize len=0x0401");
    check("big_err", load_error, 1);
    check("big_hold", cpu_hold, 0);
    check("big_clears", clr_count - c0, 0);
    check("big_writes", wr_count - w0, 0);

    // Stall after 2 of 4 payload bytes: error exactly TIMEOUT edges later.
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(16'd4, pl, 1, 5, 0);
    n = 0;
    while (!load_error && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    $display("frame stalled len=4 after 2 bytes");
    check("timeout_latency", n, 16);
    idle(2);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    d0 = done_count;
    pl = '{8'h01, 8'h02, 8'h03};
    send_frame(16'd3, pl, 1, 1000, 0);
    idle(4);
    $display("frame checksum 06");
    check("chk_good_done", done_count - d0, 1);
    check("chk_good_err", load_error, 0);
    d0 = done_count;
    send_frame(16'd3, pl, 1, 1000, 1);
    idle(4);
    $display("frame checksum 07");
    check("chk_bad_done", done_count - d0, 0);
    check("chk_bad_err", load_error, 1);
`endif

    // Randomized frames, each checked cycle by cycle by the compare process.
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(9, 0);
      gap = $urandom_range(3, 0);
      pl.delete();
      if (kind == 0) begin
        bl = ($urandom_range(1, 0) == 0) ? 16'd0 : 16'($urandom_range(65535, MEM_BYTES + 1));
        send_frame(bl, pl, gap, 3, 0);
        idle(4);
        $display("frame %0d bad length %0d", f, bl);
      end else begin
        n = ($urandom_range(1, 0) == 1) ? $urandom_range(3, 1) : $urandom_range(12, 1);
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
        if (kind == 1) begin
          send_frame(16'(n), pl, gap, $urandom_range(2 + n, 1), 0);
          idle(TIMEOUT + 4);
          $display("frame %0d truncated len=%0d", f, n);
        end else begin
          send_frame(16'(n), pl, gap, 1000, ($urandom_range(4, 0) == 0) ? 1 : 0);
          idle(4);
          $display("frame %0d len=%0d gap<=%0d", f, n, gap);
        end
      end
      repeat ($urandom_range(3, 0)) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g);
        idle($urandom_range(2, 0));
      end
    end

    // Reset pulsed after 3 payload bytes.
    pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(16'd4, pl, 0, 6, 0);
    reset = 1'b1;
    #1;
    $display("reset mid-frame");
    check("mid_rst_we", write_enable, 0);
    check("mid_rst_hold", cpu_hold, 0);
    check("mid_rst_clr", clear_mem, 0);
    check("mid_rst_done", load_done, 0);
    check("mid_rst_err", load_error, 0);
    idle(2);
    reset = 1'b0;
    w0 = wr_count; d0 = done_count;
    idle(2);
    send_byte(8'h55);
    idle(TIMEOUT + 4);
    $display("byte 0x55 after reset");
    check("post_rst_hold", cpu_hold, 0);
    check("post_rst_writes", wr_count - w0, 0);
    check("post_rst_done", done_count - d0, 0);
    check("post_rst_err", load_error, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
